// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one single-port unified memory between the instruction fetch path and
// the load/store path. Only one transaction is in flight at a time: a request is
// granted in IDLE, the memory command is held through BUSY until mem_ready (or
// until the watchdog expires), and a one-cycle acknowledge is returned in ACK.
// When both requesters are waiting in IDLE, the one that was not granted last
// wins, so neither can starve the other.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   if_req / if_address              fetch request (always a read)
//   if_ack / if_read_data            fetch completion pulse and fetched word
//   data_req / data_write            data request, 1 = store, 0 = load
//   data_address / data_write_data   load/store address and store data
//   data_ack / data_read_data        data completion pulse and load result
//   bus_error                        high with the ack when the memory timed out
//   mem_read / mem_write             memory command levels
//   mem_address / mem_write_data     latched address and store data
//   mem_read_data / mem_ready        memory read data and completion pulse
//
// Every output comes straight from a flip-flop; no input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_address,
    output logic                     if_ack,
    output logic [DATA_WIDTH-1:0]    if_read_data,
    input  logic                     data_req,
    input  logic                     data_write,
    input  logic [ADDRESS_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0]    data_write_data,
    output logic                     data_ack,
    output logic [DATA_WIDTH-1:0]    data_read_data,
    output logic                     bus_error,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_ready
);

    // The watchdog only ever counts up to TIMEOUT-1 before the abort fires, so
    // a counter wide enough for TIMEOUT can never wrap.
    localparam int                  WD_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT - 1);

    // Requester identity, used for both the current owner and last_grant.
    localparam logic OWNER_IF   = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                     state_reg, state_next;
    logic                       owner_reg, owner_next;
    logic                       last_grant_reg, last_grant_next;
    logic [WD_WIDTH-1:0]        wd_reg, wd_next;
    logic                       mem_read_reg, mem_read_next;
    logic                       mem_write_reg, mem_write_next;
    logic [ADDRESS_WIDTH-1:0]   mem_address_reg, mem_address_next;
    logic [DATA_WIDTH-1:0]      mem_write_data_reg, mem_write_data_next;
    logic                       bus_error_reg, bus_error_next;

    logic grant_if;
    logic grant_data;
    logic done_ok;
    logic done_timeout;

    // Data wins a conflict unless it was the last one served.
    assign grant_data   = (state_reg == IDLE) && data_req &&
                          (!if_req || (last_grant_reg == OWNER_IF));
    assign grant_if     = (state_reg == IDLE) && if_req && !grant_data;

    // mem_ready has priority over the watchdog on the final BUSY cycle.
    assign done_ok      = (state_reg == BUSY) && mem_ready;
    assign done_timeout = (state_reg == BUSY) && !mem_ready && (wd_reg == WD_LAST);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            owner_reg          <= OWNER_IF;
            last_grant_reg     <= OWNER_IF;
            wd_reg             <= '0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
            bus_error_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            owner_reg          <= owner_next;
            last_grant_reg     <= last_grant_next;
            wd_reg             <= wd_next;
            mem_read_reg       <= mem_read_next;
            mem_write_reg      <= mem_write_next;
            mem_address_reg    <= mem_address_next;
            mem_write_data_reg <= mem_write_data_next;
            bus_error_reg      <= bus_error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_if || grant_data)   state_next = BUSY;
            BUSY:    if (done_ok || done_timeout)  state_next = ACK;
            ACK:                                   state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values (registered above)
    // -------------------------------------------------------------------------
    always_comb begin
        owner_next          = owner_reg;
        last_grant_next     = last_grant_reg;
        wd_next             = wd_reg;
        mem_read_next       = mem_read_reg;
        mem_write_next      = mem_write_reg;
        mem_address_next    = mem_address_reg;
        mem_write_data_next = mem_write_data_reg;
        bus_error_next      = bus_error_reg;

        case (state_reg)
            IDLE: begin
                if (grant_if || grant_data) begin
                    mem_address_next    = grant_data ? data_address : if_address;
                    mem_write_data_next = grant_data ? data_write_data : '0;
                    mem_read_next       = grant_if || !data_write;
                    mem_write_next      = grant_data && data_write;
                    owner_next          = grant_data ? OWNER_DATA : OWNER_IF;
                    last_grant_next     = grant_data ? OWNER_DATA : OWNER_IF;
                    wd_next             = '0;
                    bus_error_next      = 1'b0;
                end
            end
            BUSY: begin
                if (done_ok || done_timeout) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    bus_error_next = done_timeout;
                end else begin
                    wd_next = wd_reg + WD_WIDTH'(1);
                end
            end
            ACK: begin
                // bus_error accompanies the ack pulse only.
                bus_error_next = 1'b0;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-requester ack pulse and read-data register. Index 0 is fetch,
    // index 1 is data, matching OWNER_IF / OWNER_DATA.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_req
            logic                  ack_reg;
            logic [DATA_WIDTH-1:0] read_data_reg;
            logic                  owned;

            assign owned = (owner_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    ack_reg       <= 1'b0;
                    read_data_reg <= '0;
                end else begin
                    ack_reg <= owned && (done_ok || done_timeout);
                    // Stores leave the register alone; an aborted read
                    // returns zero rather than stale data.
                    if (owned && mem_read_reg) begin
                        if (done_ok) begin
                            read_data_reg <= mem_read_data;
                        end else if (done_timeout) begin
                            read_data_reg <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    assign if_ack         = gen_req[0].ack_reg;
    assign if_read_data   = gen_req[0].read_data_reg;
    assign data_ack       = gen_req[1].ack_reg;
    assign data_read_data = gen_req[1].read_data_reg;
    assign bus_error      = bus_error_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed scenarios for fetch, store, conflict ordering, watchdog abort,
// mid-transaction reset and stray mem_ready, followed by a randomized run in
// which the bench plays both requesters and the memory. The random run checks
// every transaction against a transaction-level model: alternating grants on
// conflict, a word-array memory, and the watchdog limit.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_address;
    logic        if_ack;
    logic [31:0] if_read_data;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic        data_ack;
    logic [31:0] data_read_data;
    logic        bus_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    int checks = 0;
    int fails  = 0;

    memory_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT       (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_req          (if_req),
        .if_address      (if_address),
        .if_ack          (if_ack),
        .if_read_data    (if_read_data),
        .data_req        (data_req),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_write_data (data_write_data),
        .data_ack        (data_ack),
        .data_read_data  (data_read_data),
        .bus_error       (bus_error),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        if_req          = 1'b0;
        if_address      = '0;
        data_req        = 1'b0;
        data_write      = 1'b0;
        data_address    = '0;
        data_write_data = '0;
        mem_ready       = 1'b0;
        mem_read_data   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_ack, data_ack, bus_error, mem_read, mem_write, mem_address,
             mem_write_data, if_read_data, data_read_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: if_ack=%b data_ack=%b bus_error=%b mem_read=%b mem_write=%b addr=%h wdata=%h if_rd=%h d_rd=%h, required all 0",
                     if_ack, data_ack, bus_error, mem_read, mem_write, mem_address,
                     mem_write_data, if_read_data, data_read_data);
        end
    endtask

    task automatic test_fetch();
        if_req     = 1'b1;
        if_address = 32'h10;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h10 || if_ack !== 1'b0) begin
            fails++;
            $display("FAIL fetch_cmd: mem_read=%b mem_write=%b addr=%h if_ack=%b, required 1 0 00000010 0",
                     mem_read, mem_write, mem_address, if_ack);
        end
        mem_ready     = 1'b1;
        mem_read_data = 32'hDEADBEEF;
        tick();
        mem_ready     = 1'b0;
        mem_read_data = '0;
        checks++;
        if (if_ack !== 1'b1 || if_read_data !== 32'hDEADBEEF || bus_error !== 1'b0 ||
            data_ack !== 1'b0 || mem_read !== 1'b0) begin
            fails++;
            $display("FAIL fetch_ack: if_ack=%b rd=%h bus_error=%b data_ack=%b mem_read=%b, required 1 deadbeef 0 0 0",
                     if_ack, if_read_data, bus_error, data_ack, mem_read);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ack !== 1'b0 || mem_read !== 1'b0 || data_ack !== 1'b0) begin
            fails++;
            $display("FAIL fetch_after: if_ack=%b mem_read=%b data_ack=%b, required 0 0 0",
                     if_ack, mem_read, data_ack);
        end
    endtask

    task automatic test_store();
        data_req        = 1'b1;
        data_write      = 1'b1;
        data_address    = 32'h20;
        data_write_data = 32'h12345678;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h20 ||
                mem_write_data !== 32'h12345678 || data_ack !== 1'b0) begin
                fails++;
                $display("FAIL store_cmd_%0d: mem_write=%b mem_read=%b addr=%h wdata=%h data_ack=%b, required 1 0 00000020 12345678 0",
                         i, mem_write, mem_read, mem_address, mem_write_data, data_ack);
            end
            if (i == 3) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (mem_write !== 1'b0 || data_ack !== 1'b1 || if_ack !== 1'b0 || bus_error !== 1'b0) begin
            fails++;
            $display("FAIL store_ack: mem_write=%b data_ack=%b if_ack=%b bus_error=%b, required 0 1 0 0",
                     mem_write, data_ack, if_ack, bus_error);
        end
        data_req   = 1'b0;
        data_write = 1'b0;
        tick();
        checks++;
        if (data_ack !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL store_after: data_ack=%b mem_write=%b, required 0 0", data_ack, mem_write);
        end
    endtask

    task automatic test_conflict();
        int   ack_cnt;
        logic exp_d;
        logic [31:0] exp_rd;
        do_reset();
        if_req       = 1'b1;
        if_address   = 32'h100;
        data_req     = 1'b1;
        data_write   = 1'b0;
        data_address = 32'h200;
        ack_cnt      = 0;
        exp_d        = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            // Immediate-response memory; data is a function of the address.
            mem_ready     = mem_read | mem_write;
            mem_read_data = mem_address ^ 32'hA5A50000;
            if (if_ack || data_ack) begin
                exp_rd = (exp_d ? 32'h200 : 32'h100) ^ 32'hA5A50000;
                checks++;
                if (c != 2 + 3 * ack_cnt || data_ack !== exp_d || if_ack !== !exp_d ||
                    (exp_d ? data_read_data : if_read_data) !== exp_rd) begin
                    fails++;
                    $display("FAIL conflict_ack_%0d: cycle=%0d data_ack=%b if_ack=%b rd=%h, required cycle=%0d data_ack=%b rd=%h",
                             ack_cnt, c, data_ack, if_ack, exp_d ? data_read_data : if_read_data,
                             2 + 3 * ack_cnt, exp_d, exp_rd);
                end
                ack_cnt++;
                exp_d = !exp_d;
            end
        end
        if_req    = 1'b0;
        data_req  = 1'b0;
        mem_ready = 1'b0;
        checks++;
        if (ack_cnt != 4) begin
            fails++;
            $display("FAIL conflict_count: acks=%0d, required 4", ack_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        if_req     = 1'b1;
        if_address = 32'h40;
        mem_ready  = 1'b0;
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            tick();
            checks++;
            if (mem_read !== 1'b1 || if_ack !== 1'b0) begin
                fails++;
                $display("FAIL timeout_busy_%0d: mem_read=%b if_ack=%b, required 1 0", i, mem_read, if_ack);
            end
        end
        tick();
        checks++;
        if (mem_read !== 1'b0 || if_ack !== 1'b1 || bus_error !== 1'b1 || if_read_data !== 32'h0) begin
            fails++;
            $display("FAIL timeout_ack: mem_read=%b if_ack=%b bus_error=%b rd=%h, required 0 1 1 00000000",
                     mem_read, if_ack, bus_error, if_read_data);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ack !== 1'b0 || bus_error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: if_ack=%b bus_error=%b, required 0 0", if_ack, bus_error);
        end
        if_req     = 1'b1;
        if_address = 32'h44;
        tick();
        mem_ready     = 1'b1;
        mem_read_data = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || bus_error !== 1'b0 || if_read_data !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL timeout_recover: if_ack=%b bus_error=%b rd=%h, required 1 0 cafef00d",
                     if_ack, bus_error, if_read_data);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        data_req     = 1'b1;
        data_write   = 1'b0;
        data_address = 32'h30;
        tick();
        checks++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("FAIL midrst_busy1: mem_read=%b, required 1", mem_read);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({if_ack, data_ack, bus_error, mem_read, mem_write, mem_address,
             mem_write_data, if_read_data, data_read_data} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: if_ack=%b data_ack=%b bus_error=%b mem_read=%b mem_write=%b addr=%h rd=%h/%h, required all 0",
                     if_ack, data_ack, bus_error, mem_read, mem_write, mem_address,
                     if_read_data, data_read_data);
        end
        reset      = 1'b0;
        if_req     = 1'b1;
        if_address = 32'h50;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h30 || data_ack !== 1'b0) begin
            fails++;
            $display("FAIL midrst_grant: mem_read=%b addr=%h data_ack=%b, required 1 00000030 0",
                     mem_read, mem_address, data_ack);
        end
        mem_ready     = 1'b1;
        mem_read_data = 32'h13579BDF;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (data_ack !== 1'b1 || if_ack !== 1'b0 || data_read_data !== 32'h13579BDF) begin
            fails++;
            $display("FAIL midrst_dack: data_ack=%b if_ack=%b rd=%h, required 1 0 13579bdf",
                     data_ack, if_ack, data_read_data);
        end
        data_req = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h50) begin
            fails++;
            $display("FAIL midrst_fetch: mem_read=%b addr=%h, required 1 00000050", mem_read, mem_address);
        end
        mem_ready     = 1'b1;
        mem_read_data = 32'h2468ACE0;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || if_read_data !== 32'h2468ACE0) begin
            fails++;
            $display("FAIL midrst_iack: if_ack=%b rd=%h, required 1 2468ace0", if_ack, if_read_data);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ready();
        if_req        = 1'b0;
        data_req      = 1'b0;
        mem_ready     = 1'b1;
        mem_read_data = 32'hBAD0BAD0;
        tick();
        mem_ready     = 1'b0;
        mem_read_data = '0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (if_ack !== 1'b0 || data_ack !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
                if_read_data !== 32'h2468ACE0 || data_read_data !== 32'h13579BDF) begin
                fails++;
                $display("FAIL stray_ready_%0d: if_ack=%b data_ack=%b mem_read=%b mem_write=%b rd=%h/%h, required 0 0 0 0 2468ace0/13579bdf",
                         i, if_ack, data_ack, mem_read, mem_write, if_read_data, data_read_data);
            end
            tick();
        end
        test_fetch();
    endtask

    task automatic test_random();
        logic [31:0] mem_model [16];
        bit          if_pend, d_pend, d_wr;
        bit          in_txn, exp_ack_next, exp_err, own_d, last_d;
        bit          gen_on, just_if, just_d, e_wr;
        logic [31:0] if_a, d_a, d_wd, e_addr, e_wd, e_data;
        int          busy, lat, txn;

        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        do_reset();
        if_pend = 0; d_pend = 0; d_wr = 0;
        in_txn = 0; exp_ack_next = 0; exp_err = 0; own_d = 0;
        last_d = 0;   // after reset the last grant counts as fetch
        e_wr = 0; if_a = '0; d_a = '0; d_wd = '0; e_addr = '0; e_wd = '0; e_data = '0;
        busy = 0; lat = 0; txn = 0;

        for (int cyc = 0; cyc < 700; cyc++) begin
            gen_on        = (cyc < 600);
            just_if       = 0;
            just_d        = 0;
            mem_ready     = 1'b0;
            mem_read_data = $urandom;

            if (exp_ack_next) begin
                exp_ack_next = 0;
                in_txn       = 0;
                checks++;
                if (data_ack !== own_d || if_ack !== !own_d || bus_error !== exp_err ||
                    mem_read !== 1'b0 || mem_write !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_ack txn %0d: data_ack=%b if_ack=%b bus_error=%b cmd=%b%b, required data_ack=%b if_ack=%b bus_error=%b cmd=00",
                             txn, data_ack, if_ack, bus_error, mem_read, mem_write, own_d, !own_d, exp_err);
                end
                if (!e_wr) begin
                    checks++;
                    if ((own_d ? data_read_data : if_read_data) !== e_data) begin
                        fails++;
                        $display("FAIL rand_rdata txn %0d: got %h, required %h",
                                 txn, own_d ? data_read_data : if_read_data, e_data);
                    end
                end
                $display("txn %0d: %s %s addr=%h err=%0b", txn, own_d ? "data" : "fetch",
                         e_wr ? "write" : "read ", e_addr, exp_err);
                txn++;
                if (own_d) begin
                    d_pend = 0; data_req = 1'b0; just_d = 1;
                end else begin
                    if_pend = 0; if_req = 1'b0; just_if = 1;
                end
            end else begin
                checks++;
                if (if_ack !== 1'b0 || data_ack !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_spurious_ack cycle %0d: if_ack=%b data_ack=%b, required 0 0",
                             cyc, if_ack, data_ack);
                end
                if (in_txn || mem_read || mem_write) begin
                    if (!in_txn) begin
                        in_txn = 1;
                        busy   = 0;
                        lat    = $urandom_range(1, TB_TIMEOUT + 2);
                        checks++;
                        if (!if_pend && !d_pend) begin
                            fails++;
                            $display("FAIL rand_grant cycle %0d: command %b%b with no request pending, required none",
                                     cyc, mem_read, mem_write);
                        end
                        own_d  = (if_pend && d_pend) ? !last_d : d_pend;
                        last_d = own_d;
                        e_wr   = own_d && d_wr;
                        e_addr = own_d ? d_a : if_a;
                        e_wd   = d_wd;
                    end
                    busy++;
                    checks++;
                    if (mem_read !== !e_wr || mem_write !== e_wr || mem_address !== e_addr ||
                        (e_wr && mem_write_data !== e_wd)) begin
                        fails++;
                        $display("FAIL rand_cmd cycle %0d: rd=%b wr=%b addr=%h wdata=%h, required rd=%b wr=%b addr=%h wdata=%h",
                                 cyc, mem_read, mem_write, mem_address, mem_write_data,
                                 !e_wr, e_wr, e_addr, e_wd);
                    end
                    if (busy == lat) begin
                        mem_ready    = 1'b1;
                        exp_err      = 0;
                        exp_ack_next = 1;
                        if (e_wr) begin
                            mem_model[e_addr[5:2]] = e_wd;
                        end else begin
                            mem_read_data = mem_model[e_addr[5:2]];
                            e_data        = mem_model[e_addr[5:2]];
                        end
                    end else if (busy == TB_TIMEOUT) begin
                        exp_err      = 1;
                        e_data       = '0;
                        exp_ack_next = 1;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    mem_ready = 1'b1;   // stray pulse outside BUSY
                end
            end

            if (gen_on && !if_pend && !just_if && $urandom_range(0, 2) == 0) begin
                if_pend    = 1;
                if_a       = 32'($urandom_range(0, 15)) << 2;
                if_req     = 1'b1;
                if_address = if_a;
            end
            if (gen_on && !d_pend && !just_d && $urandom_range(0, 2) == 0) begin
                d_pend          = 1;
                d_a             = 32'($urandom_range(0, 15)) << 2;
                d_wr            = 1'($urandom_range(0, 1));
                d_wd            = $urandom;
                data_req        = 1'b1;
                data_write      = d_wr;
                data_address    = d_a;
                data_write_data = d_wd;
            end
            tick();
        end
        checks++;
        if (if_pend || d_pend || in_txn) begin
            fails++;
            $display("FAIL rand_drain: if_pend=%0b d_pend=%0b in_txn=%0b, required all 0",
                     if_pend, d_pend, in_txn);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_timeout();
        test_reset_mid_busy();
        test_stray_ready();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares one single-port unified memory between the core's instruction fetch path and its load/store path. It sits between the core and the memory: instruction fetch and data access each raise a request, and the arbiter grants one at a time. It sequences the memory command, waits for the memory's completion pulse, and returns a one-cycle acknowledge with read data. A watchdog aborts transactions the memory never completes.

## Interface
- ADDRESS_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT, 255, maximum BUSY cycles without mem_ready before abort; must be ≥1

- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  instruction fetch request (read only)
- if_address  input  ADDRESS_WIDTH  fetch address
- if_ack  output  1  one-cycle fetch completion pulse
- if_read_data  output  DATA_WIDTH  fetched word; valid while if_ack=1
- data_req  input  1  data access request
- data_write  input  1  1 = store, 0 = load; sampled with data_req
- data_address  input  ADDRESS_WIDTH  load/store address
- data_write_data  input  DATA_WIDTH  store data
- data_ack  output  1  one-cycle data completion pulse
- data_read_data  output  DATA_WIDTH  load result; valid while data_ack=1
- bus_error  output  1  high with the ack pulse when the transaction timed out
- mem_read  output  1  memory read command (level)
- mem_write  output  1  memory write command (level)
- mem_address  output  ADDRESS_WIDTH  latched address
- mem_write_data  output  DATA_WIDTH  latched store data
- mem_read_data  input  DATA_WIDTH  memory read data; valid when mem_ready=1
- mem_ready  input  1  memory completion pulse

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: if no request, stay. If exactly one request is pending, grant it. If both are pending, grant the requester other than last_grant. After reset, last_grant = instruction, so the first conflict goes to data. On grant: latch address and store data into mem_address and mem_write_data; set mem_read (fetch or load) or mem_write (store); record the owner; update last_grant; clear the watchdog; go to BUSY.
- BUSY: hold mem_read/mem_write and the latched buses unchanged. Increment the watchdog each cycle.
  - mem_ready=1: capture mem_read_data into the owner's read_data register (stores capture nothing), drop mem_read/mem_write, set bus_error=0, go to ACK.
  - Watchdog reaches TIMEOUT with no mem_ready: drop the command, leave the owner's read_data at 0, set bus_error=1, go to ACK.
- ACK: assert the owner's ack for exactly one cycle. bus_error keeps its value from BUSY. Return to IDLE. The other requester's ack stays 0.
- Requester rule: hold req, address, write and write_data stable from assertion until ack. The cycle after ack, the requester may drop req or present a new request. A req still high in IDLE is treated as a new request.
- read_data outputs keep their last captured value outside ack. They are guaranteed only during ack.
- mem_ready outside BUSY is ignored.
- Watchdog width is clog2(TIMEOUT+1). It must not wrap.
- Reset, including mid-transaction: state IDLE, the pending transaction is dropped with no ack, last_grant = instruction. All outputs reset to 0: if_ack, data_ack, bus_error, mem_read, mem_write, mem_address, mem_write_data, if_read_data, data_read_data.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request seen in IDLE at cycle N: mem command high from N+1.
- mem_ready at cycle M: command low at M+1, ack high at M+1.
- Minimum transaction with mem_ready in the first BUSY cycle: ack at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Timeout: the command is high for TIMEOUT cycles. Ack with bus_error arrives at N+TIMEOUT+1.
- A request arriving during BUSY or ACK waits. It is evaluated in the next IDLE cycle.

## Test plan
- Fetch only: if_req=1 at address 0x10, memory returns 0xDEADBEEF with mem_ready on the first BUSY cycle -> mem_read=1 for 1 cycle with mem_address=0x10; if_ack=1 for 1 cycle with if_read_data=0xDEADBEEF, bus_error=0; data_ack stays 0.
- Store: data_req=1, data_write=1, address 0x20, data 0x12345678, mem_ready after 3 cycles -> mem_write=1 for 3 cycles with stable buses; data_ack one cycle later; mem_read stays 0.
- Conflict: both requests held continuously after reset -> grant order data, fetch, data, fetch. The acks alternate, with each ack 3 cycles apart when mem_ready is immediate.
- Timeout: TIMEOUT=4, fetch issued, mem_ready never asserted -> mem_read high for exactly 4 cycles; then if_ack=1 with bus_error=1 and if_read_data=0; next transaction completes normally with bus_error=0.
- Reset mid-BUSY: assert reset during the 2nd BUSY cycle of a load -> next cycle all outputs are 0 and there is no data_ack. A fetch and a load pending simultaneously after reset release -> data is granted first.
- Stray mem_ready: pulse mem_ready in IDLE with no requests -> no ack and no state change. A subsequent fetch behaves exactly as in scenario 1.
